// File: rtl/oled_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pixel_streamer
//  Description : Walks an H_RES x V_RES frame in raster order, sources each
//                RGB565 pixel from a synchronous framebuffer or a built-in
//                pattern, and emits it MSB byte first on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_pixel_streamer #(
  parameter int H_RES  = 96,
  parameter int V_RES  = 64,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [15:0]       color_i,
  output logic [ADDR_W-1:0] fb_addr_o,
  input  logic [15:0]       fb_data_i,
  output logic [7:0]        pixel_o,
  output logic              pixel_valid_o,
  input  logic              pixel_ready_i,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int X_W       = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W       = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int BAR_W_INT = (H_RES / 8 > 0) ? H_RES / 8 : 1;

  localparam logic [X_W-1:0] X_LAST  = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_RES - 1);
  localparam logic [X_W-1:0] BAR_W   = X_W'(BAR_W_INT);
  localparam logic [X_W-1:0] BAR_MAX = X_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HI    = 3'd3,
    LO    = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [X_W-1:0]  x, x_d;
  logic [Y_W-1:0]  y, y_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     color_q, color_d;
  logic [15:0]     pix_q, pix_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]      byte_d;
  logic            done_d;
  logic            valid_d;
  logic            busy_d;
  logic [X_W-1:0]  bar_idx;
  logic [15:0]     src_pixel;

  // Pixel source selection for the current (x, y), using the frame's latched mode
  always_comb begin
    bar_idx = x / BAR_W;
    if (bar_idx > BAR_MAX) bar_idx = BAR_MAX;
    src_pixel = 16'h0000;
    case (mode_q)
      2'd0: src_pixel = fb_data_i;
      2'd1: src_pixel = color_q;
      2'd2: begin
        case (bar_idx[2:0])
          3'd0:    src_pixel = 16'hFFFF;
          3'd1:    src_pixel = 16'hFFE0;
          3'd2:    src_pixel = 16'h07FF;
          3'd3:    src_pixel = 16'h07E0;
          3'd4:    src_pixel = 16'hF81F;
          3'd5:    src_pixel = 16'hF800;
          3'd6:    src_pixel = 16'h001F;
          default: src_pixel = 16'h0000;
        endcase
      end
      default: src_pixel = (x[3] ^ y[3]) ? color_q : 16'h0000;
    endcase
  end

  // Next-state logic; registered outputs are computed from the next state so
  // they line up with the state they describe and never see pixel_ready_i
  // combinationally. The framebuffer address is kept as a running counter,
  // which equals y*H_RES + x because the walk is strictly raster order.
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    mode_d  = mode_q;
    color_d = color_q;
    pix_d   = pix_q;
    addr_d  = fb_addr_o;
    byte_d  = pixel_o;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          color_d = color_i;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        pix_d   = src_pixel;
        byte_d  = src_pixel[15:8];
        state_d = HI;
      end
      HI: begin
        if (pixel_ready_i) begin
          byte_d  = pix_q[7:0];
          state_d = LO;
        end
      end
      LO: begin
        if (pixel_ready_i) begin
          if (x < X_LAST) begin
            x_d     = x + X_W'(1);
            addr_d  = fb_addr_o + ADDR_W'(1);
            state_d = FETCH;
          end else if (y < Y_LAST) begin
            x_d     = '0;
            y_d     = y + Y_W'(1);
            addr_d  = fb_addr_o + ADDR_W'(1);
            state_d = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HI) || (state_d == LO);
    busy_d  = (state_d != IDLE);
  end

  // State, position, latched frame settings and all registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      mode_q        <= 2'd0;
      color_q       <= 16'h0000;
      pix_q         <= 16'h0000;
      fb_addr_o     <= '0;
      pixel_o       <= 8'h00;
      pixel_valid_o <= 1'b0;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      state         <= state_d;
      x             <= x_d;
      y             <= y_d;
      mode_q        <= mode_d;
      color_q       <= color_d;
      pix_q         <= pix_d;
      fb_addr_o     <= addr_d;
      pixel_o       <= byte_d;
      pixel_valid_o <= valid_d;
      busy_o        <= busy_d;
      frame_done_o  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_pixel_streamer
//  Description : Randomised self-checking bench for oled_pixel_streamer with
//                a behavioural pixel reference model and framebuffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_pixel_streamer;

  localparam int H      = 96;
  localparam int V      = 16;
  localparam int AW     = 13;
  localparam int NPIX   = H * V;
  localparam int NBYTES = 2 * NPIX;
  localparam int LIMIT  = 16 * NPIX;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode_in = 2'd0;
  logic [15:0]   color_in = 16'h0000;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data = 16'h0000;
  logic [7:0]    pixel;
  logic          valid;
  logic          ready = 1'b0;
  logic          busy;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] fb_mem [NPIX];
  logic [7:0]  rx [NBYTES];

  always #5 clk = ~clk;

  oled_pixel_streamer #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .mode_i        (mode_in),
    .color_i       (color_in),
    .fb_addr_o     (fb_addr),
    .fb_data_i     (fb_data),
    .pixel_o       (pixel),
    .pixel_valid_o (valid),
    .pixel_ready_i (ready),
    .busy_o        (busy),
    .frame_done_o  (frame_done)
  );

  // Synchronous-read framebuffer: data follows the address by one clock
  always @(posedge clk)
    fb_data <= (int'(fb_addr) < NPIX) ? fb_mem[int'(fb_addr)] : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pixel straight from the frame rules
  function automatic logic [15:0] ref_pixel(input int mode, input logic [15:0] color,
                                            input int x, input int y);
    int bar;
    case (mode)
      0: return fb_mem[y * H + x];
      1: return color;
      2: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      default: return ((((x / 8) + (y / 8)) % 2) == 1) ? color : 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rx_pix(input int x, input int y);
    return {rx[2 * (y * H + x)], rx[2 * (y * H + x) + 1]};
  endfunction

  // Runs one frame from a negedge; abort_at >= 0 resets the DUT once that many
  // bytes have been accepted.
  task automatic run_frame(input string tag, input int mode, input logic [15:0] color,
                           input int ready_pct, input int abort_at);
    int cyc, nbytes, unstable, addr_steps, addr_bad, done_cyc, bad, quiet_bad;
    logic pv, pr;
    logic [7:0] pb;
    logic [AW-1:0] pa;
    bit aborted;
    for (int i = 0; i < NBYTES; i++) rx[i] = 8'h00;
    start    = 1'b1;
    mode_in  = mode[1:0];
    color_in = color;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; nbytes = 0; unstable = 0; addr_steps = 0; addr_bad = 0;
    done_cyc = -1; aborted = 1'b0;
    check_eq({tag, "_fetch_busy"}, busy, 1);
    check_eq({tag, "_fetch_addr"}, fb_addr, 0);
    pa = fb_addr; pv = 1'b0; pr = 1'b0; pb = 8'h00;
    while (cyc < LIMIT) begin
      if (pv && !pr && (!valid || pixel !== pb)) unstable++;
      if (fb_addr !== pa) begin
        if (fb_addr == pa + 1'b1) addr_steps++;
        else addr_bad++;
        pa = fb_addr;
      end
      if (cyc == 2) check_eq({tag, "_first_valid"}, valid, 1);
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
      ready = ($urandom_range(99) < ready_pct);
      start = busy && ($urandom_range(63) == 0);
      mode_in  = 2'($urandom);
      color_in = 16'($urandom);
      if (valid && ready) begin
        if (nbytes < NBYTES) rx[nbytes] = pixel;
        nbytes++;
        if (nbytes == NBYTES) start = 1'b1;
      end
      if (abort_at >= 0 && nbytes >= abort_at) begin
        aborted = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_rst_busy"}, busy, 0);
        check_eq({tag, "_rst_valid"}, valid, 0);
        check_eq({tag, "_rst_pixel"}, pixel, 0);
        check_eq({tag, "_rst_addr"}, fb_addr, 0);
        check_eq({tag, "_rst_done"}, frame_done, 0);
        quiet_bad = 0;
        repeat (4) begin
          @(negedge clk);
          if (frame_done || busy || valid) quiet_bad++;
        end
        check_eq({tag, "_rst_quiet"}, quiet_bad, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq({tag, "_post_rst_done"}, frame_done, 0);
        break;
      end
      pv = valid; pr = ready; pb = pixel;
      @(negedge clk);
      cyc++;
    end
    if (!aborted) begin
      start = 1'b0;
      ready = 1'b0;
      check_eq({tag, "_finished"}, (done_cyc >= 0), 1);
      check_eq({tag, "_done_busy"}, busy, 0);
      check_eq({tag, "_done_valid"}, valid, 0);
      check_eq({tag, "_byte_count"}, nbytes, NBYTES);
      check_eq({tag, "_stall_unstable"}, unstable, 0);
      check_eq({tag, "_addr_steps"}, addr_steps, NPIX - 1);
      check_eq({tag, "_addr_jumps"}, addr_bad, 0);
      if (ready_pct >= 100) check_eq({tag, "_done_cycle"}, done_cyc, 4 * NPIX);
      bad = 0;
      for (int p = 0; p < NPIX; p++)
        if (rx_pix(p % H, p / H) !== ref_pixel(mode, color, p % H, p / H)) bad++;
      check_eq({tag, "_stream_errors"}, bad, 0);
      @(negedge clk);
      check_eq({tag, "_pulse_width"}, frame_done, 0);
      check_eq({tag, "_idle_after"}, busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) fb_mem[i] = 16'(i);
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_pixel", pixel, 0);
    check_eq("reset_addr", fb_addr, 0);
    check_eq("reset_done", frame_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("solid", 1, 16'hF800, 100, -1);
    check_eq("solid_byte0", rx[0], 8'hF8);
    check_eq("solid_byte1", rx[1], 8'h00);

    run_frame("fb", 0, 16'h0000, 100, -1);
    check_eq("fb_px_95_0", rx_pix(95, 0), 16'd95);
    check_eq("fb_wrap_0_1", rx_pix(0, 1), 16'd96);

    run_frame("bars", 2, 16'h0000, 100, -1);
    check_eq("bar_x0", rx_pix(0, 5), 16'hFFFF);
    check_eq("bar_x11", rx_pix(11, 5), 16'hFFFF);
    check_eq("bar_x12", rx_pix(12, 5), 16'hFFE0);
    check_eq("bar_x47", rx_pix(47, 5), 16'h07E0);
    check_eq("bar_x48", rx_pix(48, 5), 16'hF81F);
    check_eq("bar_x95", rx_pix(95, 5), 16'h0000);

    run_frame("checker", 3, 16'h001F, 100, -1);
    check_eq("chk_0_0", rx_pix(0, 0), 16'h0000);
    check_eq("chk_8_0", rx_pix(8, 0), 16'h001F);
    check_eq("chk_8_8", rx_pix(8, 8), 16'h0000);
    check_eq("chk_0_8", rx_pix(0, 8), 16'h001F);

    for (int i = 0; i < NPIX; i++) fb_mem[i] = 16'($urandom);
    run_frame("stall", 0, 16'h0000, 50, -1);

    run_frame("abort", 0, 16'h0000, 100, 2000);
    run_frame("restart", 0, 16'h0000, 70, -1);
    check_eq("restart_px0", rx_pix(0, 0), fb_mem[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
